// File: rtl/pipe_id_fwd.sv
// pipe_id_fwd -- pipeline decode stage with register file, operand bypass
// and load-use interlock.
//
// Sits between the IF/ID latch and EX. Decodes the MIPS instruction held in
// id_instr, reads both operands (with bypass from EX, MEM and WB), detects a
// load-use hazard against the instruction currently in EX, and registers the
// resulting ID/EX bundle.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_valid, id_instr           instruction from IF
//   id_ready                     ID accepts id_instr this cycle (IF holds if 0)
//   ex_stall                     EX cannot accept; hold the ID/EX bundle
//   flush                        kill the instruction entering EX
//   exr_wen/exr_wa/exr_data      combinational result of the instruction in EX
//   mem_wen/mem_wa/mem_data      result of the instruction in MEM
//   wb_wen/wb_ovf/wb_wa/wb_data  writeback port; writes when wb_wen & ~wb_ovf
//   ex_valid .. ex_load          registered ID/EX bundle
module pipe_id_fwd #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  output logic          id_ready,
  input  logic          ex_stall,
  input  logic          flush,
  input  logic          exr_wen,
  input  logic [4:0]    exr_wa,
  input  logic [DW-1:0] exr_data,
  input  logic          mem_wen,
  input  logic [4:0]    mem_wa,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_wen,
  input  logic          wb_ovf,
  input  logic [4:0]    wb_wa,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_rs_val,
  output logic [DW-1:0] ex_rt_val,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_shamt,
  output logic [5:0]    ex_op,
  output logic [5:0]    ex_func,
  output logic [4:0]    ex_wa,
  output logic          ex_wrf,
  output logic          ex_load
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG_L = 6'(NREG);

  // ---------------------------------------------------------------------
  // Field extraction and decode
  // ---------------------------------------------------------------------
  logic [5:0]    op;
  logic [5:0]    func;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [15:0]   imm16;
  logic [DW-1:0] imm_ext;
  logic [4:0]    wa;
  logic          wrf;
  logic          is_load;
  logic          uses_rt;

  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign shamt = id_instr[10:6];
  assign imm16 = id_instr[15:0];
  assign func  = id_instr[5:0];

  always_comb begin
    // andi/ori/xori/lui take a zero-extended immediate; everything else signed
    if (op >= 6'h0C && op <= 6'h0F)
      imm_ext = {{(DW-16){1'b0}}, imm16};
    else
      imm_ext = {{(DW-16){imm16[15]}}, imm16};
  end

  always_comb begin
    if (op == 6'h03)
      wa = 5'd31;
    else if (op == 6'h00)
      wa = rd;
    else
      wa = rt;
  end

  always_comb begin
    wrf = 1'b1;
    case (op)
      6'h28, 6'h29, 6'h2B: wrf = 1'b0;  // stores
      6'h04, 6'h05:        wrf = 1'b0;  // beq / bne
      6'h02:               wrf = 1'b0;  // j
      6'h00:               if (func == 6'h08) wrf = 1'b0;  // jr
      default:             wrf = 1'b1;
    endcase
    if (wa == 5'd0)
      wrf = 1'b0;
  end

  assign is_load = (op >= 6'h20) && (op <= 6'h25);

  always_comb begin
    case (op)
      6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: uses_rt = 1'b1;
      default:                                  uses_rt = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  // An index is "live" only if it is nonzero and names a physical register;
  // everything else reads as zero and is never written or forwarded.
  function automatic logic idx_live(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < NREG_L);
  endfunction

  logic          wb_we;
  logic [DW-1:0] rf [NREG];

  assign wb_we = wb_wen & ~wb_ovf & idx_live(wb_wa);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_wa[AW-1:0]] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Load-use hazard
  // ---------------------------------------------------------------------
  logic haz_rs;
  logic haz_rt;
  logic hazard;

  assign haz_rs = ex_valid & ex_load & (ex_wa != 5'd0) & (ex_wa == rs);
  assign haz_rt = ex_valid & ex_load & (ex_wa != 5'd0) & (ex_wa == rt) & uses_rt;
  assign hazard = haz_rs | haz_rt;

  assign id_ready = ~hazard & ~ex_stall;

  // ---------------------------------------------------------------------
  // Operand bypass
  // ---------------------------------------------------------------------
  // ex_ok is cleared while the EX instruction is a load targeting this
  // register: exr_data is only an address then, not the loaded value.
  function automatic logic [DW-1:0] fwd_operand(
    input logic [4:0]    idx,
    input logic [DW-1:0] rf_val,
    input logic          ex_ok
  );
    if (!idx_live(idx))
      return '0;
    else if (ex_ok && exr_wen && ex_valid && (exr_wa == idx))
      return exr_data;
    else if (mem_wen && (mem_wa == idx))
      return mem_data;
    else if (wb_we && (wb_wa == idx))
      return wb_data;
    else
      return rf_val;
  endfunction

  logic [DW-1:0] rf_rs;
  logic [DW-1:0] rf_rt;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;

  assign rf_rs = rf[rs[AW-1:0]];
  assign rf_rt = rf[rt[AW-1:0]];

  always_comb begin
    rs_val = fwd_operand(rs, rf_rs, ~haz_rs);
    rt_val = fwd_operand(rt, rf_rt, ~haz_rt);
  end

  // ---------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_shamt  <= '0;
      ex_op     <= '0;
      ex_func   <= '0;
      ex_wa     <= '0;
      ex_wrf    <= 1'b0;
      ex_load   <= 1'b0;
    end else if (flush) begin
      // killed slot; remaining fields are don't-care and simply held
      ex_valid <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      // bubble; IF keeps presenting the dependent instruction
      ex_valid <= 1'b0;
    end else begin
      ex_valid  <= id_valid;
      ex_rs_val <= rs_val;
      ex_rt_val <= rt_val;
      ex_imm    <= imm_ext;
      ex_shamt  <= shamt;
      ex_op     <= op;
      ex_func   <= func;
      ex_wa     <= wa;
      ex_wrf    <= wrf;
      ex_load   <= is_load;
    end
  end

endmodule

// File: tb/tb_pipe_id_fwd.sv
module tb_pipe_id_fwd;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic          id_ready;
  logic          ex_stall;
  logic          flush;
  logic          exr_wen;
  logic [4:0]    exr_wa;
  logic [DW-1:0] exr_data;
  logic          mem_wen;
  logic [4:0]    mem_wa;
  logic [DW-1:0] mem_data;
  logic          wb_wen;
  logic          wb_ovf;
  logic [4:0]    wb_wa;
  logic [DW-1:0] wb_data;
  logic          ex_valid;
  logic [DW-1:0] ex_rs_val;
  logic [DW-1:0] ex_rt_val;
  logic [DW-1:0] ex_imm;
  logic [4:0]    ex_shamt;
  logic [5:0]    ex_op;
  logic [5:0]    ex_func;
  logic [4:0]    ex_wa;
  logic          ex_wrf;
  logic          ex_load;

  int checks = 0;
  int errors = 0;

  pipe_id_fwd #(.DW(DW), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
    .ex_stall(ex_stall), .flush(flush),
    .exr_wen(exr_wen), .exr_wa(exr_wa), .exr_data(exr_data),
    .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_ovf(wb_ovf), .wb_wa(wb_wa), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_op(ex_op), .ex_func(ex_func),
    .ex_wa(ex_wa), .ex_wrf(ex_wrf), .ex_load(ex_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_fwd();
    exr_wen = 0; exr_wa = 0; exr_data = 0;
    mem_wen = 0; mem_wa = 0; mem_data = 0;
    wb_wen = 0; wb_ovf = 0; wb_wa = 0; wb_data = 0;
  endtask

  initial begin
    rst = 1; id_valid = 0; id_instr = 0; ex_stall = 0; flush = 0;
    clr_fwd();
    tick(); tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_rs", ex_rs_val, 0);
    chk("rst_wa", ex_wa, 0);
    chk("rst_ready", id_ready, 1);

    // r5 = 0x1234 via WB, then addu r3,r5,r0
    rst = 0;
    wb_wen = 1; wb_wa = 5; wb_data = 32'h1234;
    tick();
    clr_fwd();
    id_valid = 1; id_instr = r_ins(5, 0, 3, 'h21);
    #1 chk("t1_ready", id_ready, 1);
    tick();
    chk("t1_valid", ex_valid, 1);
    chk("t1_rs", ex_rs_val, 32'h1234);
    chk("t1_rt", ex_rt_val, 0);
    chk("t1_wa", ex_wa, 3);
    chk("t1_wrf", ex_wrf, 1);
    chk("t1_func", ex_func, 'h21);

    // WB write-through: r8 written in the same cycle it is read
    wb_wen = 1; wb_wa = 8; wb_data = 32'h77;
    id_instr = r_ins(8, 5, 10, 'h21);
    tick();
    chk("wt_rs", ex_rs_val, 32'h77);
    chk("wt_rt", ex_rt_val, 32'h1234);

    // bypass priority on r1: EX > MEM > WB > regfile
    exr_wen = 1; exr_wa = 1; exr_data = 32'hA;
    mem_wen = 1; mem_wa = 1; mem_data = 32'hB;
    wb_wen = 1; wb_wa = 1; wb_data = 32'hC;
    id_instr = r_ins(1, 1, 2, 'h20);
    tick();
    chk("fwd_ex_rs", ex_rs_val, 32'hA);
    chk("fwd_ex_rt", ex_rt_val, 32'hA);
    exr_wen = 0;
    tick();
    chk("fwd_mem_rs", ex_rs_val, 32'hB);
    chk("fwd_mem_rt", ex_rt_val, 32'hB);
    mem_wen = 0;
    tick();
    chk("fwd_wb_rs", ex_rs_val, 32'hC);
    wb_wen = 0;
    tick();
    chk("fwd_rf_rt", ex_rt_val, 32'hC);

    // load-use: lw r4,0(r2) then addu r6,r4,r1
    clr_fwd();
    id_instr = i_ins('h23, 2, 4, 0);
    tick();
    chk("lw_load", ex_load, 1);
    chk("lw_wa", ex_wa, 4);
    id_instr = r_ins(4, 1, 6, 'h21);
    #1 chk("lu_ready0", id_ready, 0);
    tick();
    chk("lu_bubble", ex_valid, 0);
    mem_wen = 1; mem_wa = 4; mem_data = 32'h55;
    #1 chk("lu_ready1", id_ready, 1);
    tick();
    chk("lu_valid", ex_valid, 1);
    chk("lu_rs_mem", ex_rs_val, 32'h55);
    chk("lu_rt", ex_rt_val, 32'hC);
    chk("lu_wa", ex_wa, 6);

    // lw r4 then addiu r7,r0,-1: rt not a source, no stall
    clr_fwd();
    id_instr = i_ins('h23, 2, 4, 0);
    tick();
    id_instr = i_ins('h09, 0, 7, 'hFFFF);
    #1 chk("nolu_ready", id_ready, 1);
    tick();
    chk("addiu_valid", ex_valid, 1);
    chk("addiu_imm", ex_imm, 32'hFFFF_FFFF);
    chk("addiu_wa", ex_wa, 7);
    id_instr = i_ins('h0D, 0, 7, 'h8000);
    tick();
    chk("ori_imm", ex_imm, 32'h0000_8000);

    // rt-side load-use through a store: lw r4 then sw r4,0(r2)
    id_instr = i_ins('h23, 2, 4, 0);
    tick();
    id_instr = i_ins('h2B, 2, 4, 0);
    #1 chk("lu_rt_ready", id_ready, 0);
    tick();
    tick();
    chk("sw_wrf", ex_wrf, 0);
    chk("sw_wa", ex_wa, 4);

    // jal -> r31, jr -> no write
    id_instr = {6'h03, 26'h10};
    tick();
    chk("jal_wa", ex_wa, 31);
    chk("jal_wrf", ex_wrf, 1);
    id_instr = r_ins(31, 0, 0, 'h08);
    tick();
    chk("jr_wrf", ex_wrf, 0);

    // gated WB: overflow suppresses write and write-through
    wb_wen = 1; wb_ovf = 1; wb_wa = 9; wb_data = 32'h99;
    id_instr = r_ins(9, 0, 11, 'h21);
    tick();
    chk("ovf_wt", ex_rs_val, 0);
    clr_fwd();
    tick();
    chk("ovf_rf", ex_rs_val, 0);

    // write to r0 ignored
    wb_wen = 1; wb_wa = 0; wb_data = 32'h5;
    id_instr = r_ins(0, 0, 11, 'h21);
    tick();
    chk("r0_rs", ex_rs_val, 0);

    // r20 beyond NREG=16: ignored, must not alias onto r4
    wb_wen = 1; wb_wa = 20; wb_data = 32'h20;
    id_instr = r_ins(20, 4, 11, 'h21);
    tick();
    chk("r20_wt", ex_rs_val, 0);
    chk("r20_alias_wt", ex_rt_val, 0);
    clr_fwd();
    id_instr = r_ins(4, 20, 11, 'h21);
    tick();
    chk("r20_alias_rf", ex_rs_val, 0);
    chk("r20_rf", ex_rt_val, 0);

    // stall 3 cycles then flush
    id_instr = r_ins(5, 0, 3, 'h21);
    tick();
    chk("st_pre_rs", ex_rs_val, 32'h1234);
    ex_stall = 1;
    id_instr = i_ins('h0D, 0, 7, 'h8000);
    #1 chk("st_ready", id_ready, 0);
    tick(); tick(); tick();
    chk("st_hold_valid", ex_valid, 1);
    chk("st_hold_func", ex_func, 'h21);
    chk("st_hold_rs", ex_rs_val, 32'h1234);
    chk("st_hold_op", ex_op, 0);
    flush = 1;
    tick();
    chk("st_flush", ex_valid, 0);
    flush = 0; ex_stall = 0;

    // flush together with a load-use hazard
    id_instr = i_ins('h23, 2, 4, 0);
    tick();
    id_instr = r_ins(4, 1, 6, 'h21);
    flush = 1;
    #1 chk("fh_ready", id_ready, 0);
    tick();
    chk("fh_valid", ex_valid, 0);
    flush = 0;

    // reset during a stall
    id_instr = r_ins(5, 0, 3, 'h21);
    tick();
    chk("rs_pre_valid", ex_valid, 1);
    ex_stall = 1;
    rst = 1;
    tick();
    chk("rs_valid", ex_valid, 0);
    chk("rs_rs", ex_rs_val, 0);
    chk("rs_func", ex_func, 0);
    chk("rs_imm", ex_imm, 0);
    rst = 0; ex_stall = 0;
    tick();
    chk("rs_rf_clear", ex_rs_val, 0);
    chk("rs_post_valid", ex_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
